// File: rtl/spi_sipo_rx.sv
// ----------------------------------------------------------------------------
// spi_sipo_rx
//
// Receive stage for the SPI link. It oversamples sclk_in, sdata_in and
// cs_n_in on clk and shifts in one word per frame, least significant bit
// first. The finished word is held on data_out with a valid/ack handshake.
// Early frame aborts and overwritten (unacknowledged) words are flagged.
//
// Optional feature macro: SIPO_PARITY_EN
//   defined   : data_out[DATA_W-1] carries odd parity over the lower bits,
//               and parity_err is registered with each completed word.
//   undefined : parity_err is tied low and every bit is payload.
//
// Ports
//   clk         system clock; every flop is clocked by it
//   reset_n     asynchronous, active-low reset
//   sclk_in     serial clock, asynchronous to clk, idles high
//   sdata_in    serial data, sampled on rising sclk_in
//   cs_n_in     active-low frame select, asynchronous to clk
//   data_ack    consumer acknowledge; clears data_valid
//   data_out    last completed word (bit 0 = first bit received)
//   data_valid  data_out holds an unacknowledged word
//   busy        frame in progress (SHIFT or WAIT_END)
//   frame_err   one-clk pulse when a frame ends before DATA_W bits
//   overrun     sticky: a word was overwritten before being acknowledged
//   parity_err  parity status of data_out
// ----------------------------------------------------------------------------
module spi_sipo_rx #(
    parameter int DATA_W = 9
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              sclk_in,
    input  logic              sdata_in,
    input  logic              cs_n_in,
    input  logic              data_ack,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              busy,
    output logic              frame_err,
    output logic              overrun,
    output logic              parity_err
);

    localparam int                CNT_W    = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT    = 2'd1,
        WAIT_END = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // Input synchronizers: [0] and [1] are the two-flop synchronizer, [2] is
    // the history flop used for edge detection.
    // ------------------------------------------------------------------------
    logic [2:0] sclk_pipe_reg;
    logic [2:0] sdata_pipe_reg;
    logic [2:0] cs_pipe_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_pipe_reg  <= 3'b111;
            sdata_pipe_reg <= 3'b111;
            cs_pipe_reg    <= 3'b111;
        end else begin
            sclk_pipe_reg  <= {sclk_pipe_reg[1:0],  sclk_in};
            sdata_pipe_reg <= {sdata_pipe_reg[1:0], sdata_in};
            cs_pipe_reg    <= {cs_pipe_reg[1:0],    cs_n_in};
        end
    end

    logic sclk_rise;
    logic cs_fall;
    logic cs_rise;
    logic sdata_bit;

    assign sclk_rise = sclk_pipe_reg[1] & ~sclk_pipe_reg[2];
    assign cs_fall   = ~cs_pipe_reg[1] &  cs_pipe_reg[2];
    assign cs_rise   =  cs_pipe_reg[1] & ~cs_pipe_reg[2];
    // The link holds sdata stable for several clk periods around the rising
    // sclk, so the history stage carries the same bit as the synchronized
    // stage when sclk_rise is seen.
    assign sdata_bit = sdata_pipe_reg[2];

    // ------------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------------
    state_t              state_reg;
    state_t              state_next;
    logic [CNT_W-1:0]    bit_cnt_reg;
    logic [DATA_W-1:0]   shift_reg;
    logic [DATA_W-1:0]   shift_next;
    logic                word_done;
    logic                frame_abort;

    assign shift_next = {sdata_bit, shift_reg[DATA_W-1:1]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        word_done   = 1'b0;
        frame_abort = 1'b0;
        case (state_reg)
            IDLE: begin
                if (cs_fall) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (sclk_rise && (bit_cnt_reg == CNT_LAST)) begin
                    // Final bit wins over a simultaneous cs_rise: the word is
                    // complete, so the frame ends cleanly.
                    word_done  = 1'b1;
                    state_next = cs_rise ? IDLE : WAIT_END;
                end else if (cs_rise) begin
                    frame_abort = 1'b1;
                    state_next  = IDLE;
                end
            end
            WAIT_END: begin
                if (cs_rise) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        busy = (state_reg != IDLE);
    end

    // ------------------------------------------------------------------------
    // Shift register and bit counter. The counter is cleared whenever the
    // FSM sits in or returns to IDLE, so it is zero on entry to SHIFT and
    // never wraps (it stops at DATA_W in WAIT_END).
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shift_reg   <= '0;
            bit_cnt_reg <= '0;
        end else begin
            if (state_reg == SHIFT && sclk_rise) begin
                shift_reg <= shift_next;
            end
            if (state_reg == IDLE || state_next == IDLE) begin
                bit_cnt_reg <= '0;
            end else if (state_reg == SHIFT && sclk_rise) begin
                bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Output register and handshake
    // ------------------------------------------------------------------------
    logic [DATA_W-1:0] data_out_reg;
    logic              data_valid_reg;
    logic              overrun_reg;
    logic              frame_err_reg;
    logic              overrun_set;

    // Only a completion against a still-pending word with no ack this cycle
    // is an overrun; a coincident ack hands the old word over in time.
    assign overrun_set = word_done & data_valid_reg & ~data_ack;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out_reg   <= '0;
            data_valid_reg <= 1'b0;
            overrun_reg    <= 1'b0;
            frame_err_reg  <= 1'b0;
        end else begin
            if (word_done) begin
                data_out_reg <= shift_next;
            end
            data_valid_reg <= word_done | (data_valid_reg & ~data_ack);
            overrun_reg    <= overrun_set | (overrun_reg & ~data_ack);
            frame_err_reg  <= frame_abort;
        end
    end

`ifdef SIPO_PARITY_EN
    logic parity_err_reg;

    // Odd parity: a good word has an odd number of ones in all DATA_W bits.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            parity_err_reg <= 1'b0;
        end else if (word_done) begin
            parity_err_reg <= ~(^shift_next);
        end
    end

    assign parity_err = parity_err_reg;
`else
    assign parity_err = 1'b0;
`endif

    assign data_out   = data_out_reg;
    assign data_valid = data_valid_reg;
    assign overrun    = overrun_reg;
    assign frame_err  = frame_err_reg;

endmodule

// File: doc/spi_sipo_rx.md
# spi_sipo_rx

Serial-in/parallel-out receive stage that sits directly downstream of the switch-driven PISO serializer on the SPI link. It oversamples the incoming serial clock, data and chip-select on the system clock, shifts in one LSB-first word per frame, and presents it on a parallel output register with a valid/ack handshake. Framing and overrun errors are flagged. Its output drives the LED/display consumers.

## Interface
- DATA_W, 9, bits per frame and width of data_out. Legal range 2..16.
- clk  in  1  system clock. All logic is synchronous to it.
- reset_n  in  1  reset: asynchronous, active-low.
- sclk_in  in  1  serial clock from the link, asynchronous to clk. Idles high.
- sdata_in  in  1  serial data, asynchronous to clk. Sampled on rising sclk_in.
- cs_n_in  in  1  frame select, active-low, asynchronous to clk.
- data_ack  in  1  consumer acknowledge; clears data_valid.
- data_out  out  DATA_W  last completed word. Bit 0 is the first bit received.
- data_valid  out  1  data_out holds an unacknowledged word.
- busy  out  1  high while a frame is in progress (state SHIFT or WAIT_END).
- frame_err  out  1  one-clk pulse when a frame is aborted early.
- overrun  out  1  sticky flag: a word was overwritten before it was acknowledged.
- parity_err  out  1  parity status of data_out (see Configuration).

## Operation
- Synchronizers: sclk_in, sdata_in and cs_n_in each pass through a 2-flop synchronizer, then through 1 history flop for edge detection.
  - Reset values: sclk and cs_n stages reset to 1; sdata stages reset to 1.
- sclk_rise is the synchronized sclk 0->1. cs_fall and cs_rise are the synchronized cs_n edges. Data is captured from the synchronized sdata stage that is aligned with sclk_rise.
- States:
  - IDLE: cs_n high. bit_cnt = 0.
    - cs_fall -> SHIFT, with bit_cnt cleared.
  - SHIFT: on each sclk_rise, shift_reg <= {sdata, shift_reg[DATA_W-1:1]} and bit_cnt++.
    - On the sclk_rise that makes bit_cnt == DATA_W: load data_out from the completed shift value, set data_valid, update parity_err, go to WAIT_END.
    - cs_rise with bit_cnt < DATA_W: pulse frame_err, discard the partial word (data_out and data_valid unchanged), go to IDLE.
  - WAIT_END: further sclk_rise edges are ignored.
    - cs_rise -> IDLE.
- bit_cnt is $clog2(DATA_W+1) bits wide and never wraps; it is cleared on entry to SHIFT.
- Handshake:
  - data_valid clears on the clk edge where data_ack=1. An ack while data_valid=0 has no effect.
  - A word completes while data_valid=1 and data_ack=0: data_out is overwritten, data_valid stays 1, and overrun sets.
  - A word completes in the same cycle as data_ack=1: the new word is loaded, data_valid stays 1, and overrun is not set.
  - overrun clears only on reset or on data_ack=1 (unless that same cycle sets it).
- Simultaneous final sclk_rise and cs_rise in the same clk cycle: the bit is taken, the word completes, frame_err=0, next state IDLE.
- cs_fall in WAIT_END cannot occur without a prior cs_rise. cs_fall while in SHIFT is impossible by construction.
- Reset mid-frame: all state returns to IDLE immediately and the partial word is lost.
- Reset values: data_out=0, data_valid=0, busy=0, frame_err=0, overrun=0, parity_err=0, shift_reg=0, bit_cnt=0.

## Timing
- Pin-to-detect latency: 3 clk edges (2 sync + 1 history). The edge is acted on at the 3rd rising clk edge after the pin transition.
- data_out and data_valid update on the same clk edge that detects the final sclk_rise.
- busy rises 1 cycle after cs_fall is detected and falls 1 cycle after cs_rise is detected.
- Constraints on the link:
  - sclk_in high and low phases must each last ≥ 3 clk periods.
  - sdata_in must be stable for ≥ 3 clk periods around the rising sclk_in.
  - cs_n_in must be low ≥ 3 clk before the first sclk rise.
- Throughput: one word per frame. No back-pressure on the link; overrun is the only protection.

## Configuration
- SIPO_PARITY_EN defined:
  - data_out[DATA_W-1] is an odd-parity bit over data_out[DATA_W-2:0].
  - parity_err is registered with each completed word: 1 when the XOR of all DATA_W bits equals 0.
  - parity_err holds until the next completed word or reset.
- SIPO_PARITY_EN undefined: parity_err is tied to 0, and all DATA_W bits are payload.

## Test plan
- Nominal frame, DATA_W=9, sclk phase 8 clk: cs_n low, send 9'h1A5 LSB first, cs_n high -> data_out=9'h1A5, data_valid=1, frame_err=0, busy low 1 clk after cs_rise detect.
- Early abort: cs_n rises after 5 bits -> frame_err one-cycle pulse, data_out/data_valid unchanged, state IDLE, next full frame 9'h0F0 received correctly.
- Overrun: send 9'h055 with no ack, then 9'h0AA -> data_out=9'h0AA, overrun=1. Pulse data_ack -> data_valid=0, overrun=0.
- Ack coincident with completion: assert data_ack on the completing edge of the second word 9'h133 -> data_valid=1, data_out=9'h133, overrun=0.
- Reset mid-frame after 4 bits -> all outputs 0, busy=0. Full frame 9'h1FF afterwards -> data_out=9'h1FF.
- SIPO_PARITY_EN: send 9'h101 (XOR=0) -> parity_err=1. Send 9'h001 (XOR=1) -> parity_err=0. With the macro undefined, parity_err stays 0 for both words.
